// File: rtl/ltc2600_channel_sequencer.sv
// LTC2600 channel sequencer: per-channel shadow codes with dirty bits, issuing
// one single-channel frame at a time to the serial writer, lowest channel first.
// With SYNC_UPDATE set, channels are written without update and a trailing
// update-all command makes every output change together.
module ltc2600_channel_sequencer #(
  parameter int N_CH           = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int SYNC_UPDATE    = 0,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ch_wr_en,
  input  logic [AW-1:0]         ch_wr_addr,
  input  logic [DATA_WIDTH-1:0] ch_wr_data,
  input  logic                  refresh_all,
  input  logic                  err_clr,
  input  logic                  write_complete,
  output logic                  send_new_cmd,
  output logic [3:0]            command,
  output logic [3:0]            address,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic [N_CH-1:0]       dirty,
  output logic                  seq_done,
  output logic                  err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] CMD_WR  = (SYNC_UPDATE != 0) ? 4'b0000 : 4'b0011;
  localparam logic [3:0] CMD_UPD = 4'b0001;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPD_ISSUE, UPD_WAIT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shadow [N_CH];
  logic [AW-1:0]         cur_idx;
  logic [AW-1:0]         low_idx;
  logic [TW-1:0]         tmo_cnt;
  logic                  pass_open;
  logic                  wr_ok;
  logic                  in_wait;
  logic                  tmo_hit;
  logic [N_CH-1:0]       dirty_nxt;

  assign busy    = (state != IDLE);
  assign wr_ok   = ch_wr_en && (int'(ch_wr_addr) < N_CH);
  assign in_wait = (state == WAIT) || (state == UPD_WAIT);
  // A completion arriving on the last allowed cycle still counts as on time.
  assign tmo_hit = in_wait && !write_complete && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Lowest pending channel: scan downward so the last match is the lowest index.
  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (dirty[i]) low_idx = AW'(i);
  end

  // Dirty bitmap update; host sets are applied last so they win over the
  // clear in ISSUE and a rewritten channel gets re-sent.
  always_comb begin
    dirty_nxt = dirty;
    if (state == ISSUE) dirty_nxt[cur_idx] = 1'b0;
    if (state == WAIT && tmo_hit) dirty_nxt[cur_idx] = 1'b1;
    if (refresh_all) dirty_nxt = '1;
    if (wr_ok) dirty_nxt[ch_wr_addr] = 1'b1;
  end

  // Shadow code table, written by the host side.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
    end else if (wr_ok) begin
      shadow[ch_wr_addr] <= ch_wr_data;
    end
  end

  // Sequencer FSM with registered command outputs, pulses and error flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      dirty        <= '0;
      send_new_cmd <= 1'b0;
      seq_done     <= 1'b0;
      err_timeout  <= 1'b0;
      command      <= 4'hF;
      address      <= 4'h0;
      data         <= '0;
      cur_idx      <= '0;
      tmo_cnt      <= '0;
      pass_open    <= 1'b0;
    end else begin
      dirty        <= dirty_nxt;
      send_new_cmd <= 1'b0;
      seq_done     <= 1'b0;
      // A fresh timeout beats a simultaneous clear.
      if (tmo_hit) err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (!err_timeout && (dirty != '0)) begin
            cur_idx      <= low_idx;
            command      <= CMD_WR;
            address      <= 4'(low_idx);
            data         <= shadow[low_idx];
            send_new_cmd <= 1'b1;
            state        <= ISSUE;
            if (SYNC_UPDATE != 0) pass_open <= 1'b1;
          end else if (!err_timeout && pass_open) begin
            command      <= CMD_UPD;
            address      <= 4'hF;
            send_new_cmd <= 1'b1;
            state        <= UPD_ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (write_complete) begin
            state <= IDLE;
            if ((SYNC_UPDATE == 0) && (dirty == '0)) seq_done <= 1'b1;
          end else if (tmo_hit) begin
            state <= IDLE;
          end else if (~&tmo_cnt) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        UPD_ISSUE: begin
          tmo_cnt <= '0;
          state   <= UPD_WAIT;
        end
        UPD_WAIT: begin
          if (write_complete) begin
            state     <= IDLE;
            pass_open <= 1'b0;
            seq_done  <= 1'b1;
          end else if (tmo_hit) begin
            state <= IDLE;
          end else if (~&tmo_cnt) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
